// File: rtl/wfq_req_arbiter.sv
// rtl/wfq_req_arbiter.sv - round-robin front end sharing one WFQ rank engine between requesters
//
// Purpose:
//   Arbitrates NUM_REQ requesters onto a single WFQ rank-calculation engine
//   whose per-class read-modify-write spans ENGINE_LAT cycles. A class that
//   is still inside that read-modify-write window is never re-issued. Each
//   engine result is steered back to the requester that issued it, and the
//   most recent PIFO dequeue (overflow, round) is presented to the engine.
//   The engine takes its reset from the same rst as this block.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   req_valid / req_ready      per-requester handshake (ready is one-hot or zero)
//   req_class_id               packed class ids, requester i at slice i
//   req_div_quotient/remain    packed quotient / remainder per requester
//   eng_req_*                  registered request towards the engine
//   eng_last_pifo_*            last dequeued PIFO rank towards the engine
//   eng_resp_valid/data        result returning from the engine
//   deq_valid/overflow/round   PIFO dequeue event
//   resp_valid / resp_data     one-hot result strobe and result data
//   err_tag_mismatch           sticky: engine response did not line up with a tag

module wfq_req_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int REQ_IDX_WIDTH       = 2,
  parameter int CLASS_WIDTH         = 5,
  parameter int WEIGHT_WIDTH        = 16,
  parameter int PIFO_OVERFLOW_WIDTH = 1,
  parameter int PIFO_ROUND_WIDTH    = 18,
  parameter int RESULT_WIDTH        = 32,
  parameter int ENGINE_LAT          = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*CLASS_WIDTH-1:0]      req_class_id,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]     req_div_quotient,
  input  logic [NUM_REQ*WEIGHT_WIDTH-1:0]     req_div_remain,
  output logic                                eng_req_valid,
  output logic [CLASS_WIDTH-1:0]              eng_req_class_id,
  output logic [WEIGHT_WIDTH-1:0]             eng_req_div_quotient,
  output logic [WEIGHT_WIDTH-1:0]             eng_req_div_remain,
  output logic                                eng_last_pifo_valid,
  output logic [PIFO_OVERFLOW_WIDTH-1:0]      eng_last_pifo_overflow,
  output logic [PIFO_ROUND_WIDTH-1:0]         eng_last_pifo_round,
  input  logic                                eng_resp_valid,
  input  logic [RESULT_WIDTH-1:0]             eng_resp_data,
  input  logic                                deq_valid,
  input  logic [PIFO_OVERFLOW_WIDTH-1:0]      deq_overflow,
  input  logic [PIFO_ROUND_WIDTH-1:0]         deq_round,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [RESULT_WIDTH-1:0]             resp_data,
  output logic                                err_tag_mismatch
);

  // A class written by the engine becomes readable again by its stage-1
  // lookup ENGINE_LAT-1 cycles after acceptance, so that is the hazard window.
  localparam int HZ = ENGINE_LAT - 1;
  localparam logic [REQ_IDX_WIDTH-1:0] LAST_IDX = REQ_IDX_WIDTH'(NUM_REQ - 1);

  // Unpacked views of the packed requester fields
  logic [CLASS_WIDTH-1:0]  cls [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] quo [NUM_REQ];
  logic [WEIGHT_WIDTH-1:0] rem [NUM_REQ];

  // Arbitration state
  logic [REQ_IDX_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]       hazard;
  logic [NUM_REQ-1:0]       elig;
  logic                     grant_any;
  logic [REQ_IDX_WIDTH-1:0] winner;

  // Hazard scoreboard: classes accepted in the last HZ cycles
  logic [HZ-1:0]            sb_vld;
  logic [CLASS_WIDTH-1:0]   sb_cls [HZ];

  // Requester index travelling with the issued request
  logic [REQ_IDX_WIDTH-1:0] issue_tag;
  logic [ENGINE_LAT-1:0]    tag_vld;
  logic [REQ_IDX_WIDTH-1:0] tag_idx [ENGINE_LAT];
  logic [NUM_REQ-1:0]       tail_onehot;
  logic                     tail_vld;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cls[i] = req_class_id[i*CLASS_WIDTH +: CLASS_WIDTH];
      quo[i] = req_div_quotient[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      rem[i] = req_div_remain[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
  end

  // A requester is eligible when valid and its class is outside the window.
  always_comb begin
    hazard = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int s = 0; s < HZ; s++) begin
        if (sb_vld[s] && (sb_cls[s] == cls[i])) begin
          hazard[i] = 1'b1;
        end
      end
    end
    elig = req_valid & ~hazard;
  end

  // First eligible requester at or above the pointer, wrapping around.
  always_comb begin
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    winner    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!grant_any && elig[idx]) begin
        grant_any = 1'b1;
        winner    = idx[REQ_IDX_WIDTH-1:0];
      end
    end
  end

  // Ready is combinational and forced low while reset is asserted so that
  // every output reads zero as soon as rst rises.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_any && !rst && (winner == REQ_IDX_WIDTH'(i));
    end
  end

  assign tail_vld = tag_vld[ENGINE_LAT-1];

  always_comb begin
    tail_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tail_onehot[i] = (tag_idx[ENGINE_LAT-1] == REQ_IDX_WIDTH'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr                 <= '0;
      eng_req_valid          <= 1'b0;
      eng_req_class_id       <= '0;
      eng_req_div_quotient   <= '0;
      eng_req_div_remain     <= '0;
      issue_tag              <= '0;
      sb_vld                 <= '0;
      for (int s = 0; s < HZ; s++) begin
        sb_cls[s] <= '0;
      end
      tag_vld                <= '0;
      for (int s = 0; s < ENGINE_LAT; s++) begin
        tag_idx[s] <= '0;
      end
      resp_valid             <= '0;
      resp_data              <= '0;
      err_tag_mismatch       <= 1'b0;
      eng_last_pifo_valid    <= 1'b0;
      eng_last_pifo_overflow <= '0;
      eng_last_pifo_round    <= '0;
    end else begin
      // Pointer moves past the winner; a skipped requester does not move it.
      if (grant_any) begin
        rr_ptr <= (winner == LAST_IDX) ? '0 : winner + REQ_IDX_WIDTH'(1);
      end

      // Issue register
      eng_req_valid <= grant_any;
      if (grant_any) begin
        eng_req_class_id     <= cls[winner];
        eng_req_div_quotient <= quo[winner];
        eng_req_div_remain   <= rem[winner];
        issue_tag            <= winner;
      end

      // Scoreboard shifts every cycle; empty slots carry valid=0.
      sb_vld[0] <= grant_any;
      sb_cls[0] <= cls[winner];
      for (int s = 1; s < HZ; s++) begin
        sb_vld[s] <= sb_vld[s-1];
        sb_cls[s] <= sb_cls[s-1];
      end

      // Tag pipe follows the engine pipe, ENGINE_LAT stages behind issue.
      tag_vld[0] <= eng_req_valid;
      tag_idx[0] <= issue_tag;
      for (int s = 1; s < ENGINE_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_idx[s] <= tag_idx[s-1];
      end

      // Responses without a matching tag are dropped and flagged.
      if (eng_resp_valid && tail_vld) begin
        resp_valid <= tail_onehot;
        resp_data  <= eng_resp_data;
      end else begin
        resp_valid <= '0;
      end
      if (eng_resp_valid != tail_vld) begin
        err_tag_mismatch <= 1'b1;
      end

      // Last-dequeue tracker, independent of issue
      if (deq_valid) begin
        eng_last_pifo_valid    <= 1'b1;
        eng_last_pifo_overflow <= deq_overflow;
        eng_last_pifo_round    <= deq_round;
      end
    end
  end

endmodule

// File: tb/tb_wfq_req_arbiter.sv
// tb/tb_wfq_req_arbiter.sv - self-checking bench for wfq_req_arbiter
`timescale 1ns/1ps

module tb_wfq_req_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int CW = 5;
  localparam int WW = 16;
  localparam int OW = 1;
  localparam int RW = 18;
  localparam int DW = 32;
  localparam int NCYC = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*CW-1:0] req_class_id;
  logic [N*WW-1:0] req_div_quotient;
  logic [N*WW-1:0] req_div_remain;
  logic            eng_req_valid;
  logic [CW-1:0]   eng_req_class_id;
  logic [WW-1:0]   eng_req_div_quotient;
  logic [WW-1:0]   eng_req_div_remain;
  logic            eng_last_pifo_valid;
  logic [OW-1:0]   eng_last_pifo_overflow;
  logic [RW-1:0]   eng_last_pifo_round;
  logic            eng_resp_valid;
  logic [DW-1:0]   eng_resp_data;
  logic            deq_valid;
  logic [OW-1:0]   deq_overflow;
  logic [RW-1:0]   deq_round;
  logic [N-1:0]    resp_valid;
  logic [DW-1:0]   resp_data;
  logic            err_tag_mismatch;

  int checks = 0;
  int errors = 0;

  // Random-test expectation tables, indexed by cycle
  bit          x_ev  [512];
  logic [CW-1:0] x_ec [512];
  logic [WW-1:0] x_eq [512];
  logic [WW-1:0] x_er [512];
  bit          x_dv  [512];
  logic [DW-1:0] x_dd [512];
  logic [N-1:0]  x_rv [512];
  logic [DW-1:0] x_rd [512];

  always #10 clk = ~clk;

  wfq_req_arbiter #(
    .NUM_REQ(N), .REQ_IDX_WIDTH(IW), .CLASS_WIDTH(CW), .WEIGHT_WIDTH(WW),
    .PIFO_OVERFLOW_WIDTH(OW), .PIFO_ROUND_WIDTH(RW), .RESULT_WIDTH(DW), .ENGINE_LAT(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_class_id(req_class_id),
    .req_div_quotient(req_div_quotient), .req_div_remain(req_div_remain),
    .eng_req_valid(eng_req_valid), .eng_req_class_id(eng_req_class_id),
    .eng_req_div_quotient(eng_req_div_quotient), .eng_req_div_remain(eng_req_div_remain),
    .eng_last_pifo_valid(eng_last_pifo_valid), .eng_last_pifo_overflow(eng_last_pifo_overflow),
    .eng_last_pifo_round(eng_last_pifo_round),
    .eng_resp_valid(eng_resp_valid), .eng_resp_data(eng_resp_data),
    .deq_valid(deq_valid), .deq_overflow(deq_overflow), .deq_round(deq_round),
    .resp_valid(resp_valid), .resp_data(resp_data), .err_tag_mismatch(err_tag_mismatch)
  );

  task automatic clear_inputs();
    req_valid        = '0;
    req_class_id     = '0;
    req_div_quotient = '0;
    req_div_remain   = '0;
    eng_resp_valid   = 1'b0;
    eng_resp_data    = '0;
    deq_valid        = 1'b0;
    deq_overflow     = '0;
    deq_round        = '0;
  endtask

  task automatic set_req(input int i, input logic [CW-1:0] c, input logic [WW-1:0] q,
                         input logic [WW-1:0] r);
    req_valid[i] = 1'b1;
    req_class_id[i*CW +: CW]     = c;
    req_div_quotient[i*WW +: WW] = q;
    req_div_remain[i*WW +: WW]   = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    req_valid = '1;
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++; if (eng_req_valid !== 1'b0) begin errors++; $display("FAIL reset_eng_valid got=%b exp=0", eng_req_valid); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
    checks++; if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_tag_mismatch); end
    checks++; if (eng_last_pifo_valid !== 1'b0) begin errors++; $display("FAIL reset_lp_valid got=%b exp=0", eng_last_pifo_valid); end
    do_reset();
  endtask

  task automatic test_single();
    logic [DW-1:0] d;
    d = $urandom;
    do_reset();
    @(negedge clk);
    set_req(2, 5'd5, 16'd10, 16'd0);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (eng_req_valid !== 1'b1) begin errors++; $display("FAIL single_issue_valid got=%b exp=1", eng_req_valid); end
    checks++; if (eng_req_class_id !== 5'd5) begin errors++; $display("FAIL single_issue_class got=%0d exp=5", eng_req_class_id); end
    checks++; if (eng_req_div_quotient !== 16'd10) begin errors++; $display("FAIL single_issue_quo got=%0d exp=10", eng_req_div_quotient); end
    checks++; if (eng_req_div_remain !== 16'd0) begin errors++; $display("FAIL single_issue_rem got=%0d exp=0", eng_req_div_remain); end
    @(negedge clk);
    #1;
    checks++; if (eng_req_valid !== 1'b0) begin errors++; $display("FAIL single_issue_once got=%b exp=0", eng_req_valid); end
    @(negedge clk);
    @(negedge clk);
    eng_resp_valid = 1'b1;
    eng_resp_data  = d;
    #1;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_early got=%b exp=0000", resp_valid); end
    @(negedge clk);
    eng_resp_valid = 1'b0;
    #1;
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL single_resp_valid got=%b exp=0100", resp_valid); end
    checks++; if (resp_data !== d) begin errors++; $display("FAIL single_resp_data got=%h exp=%h", resp_data, d); end
    checks++; if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL single_err got=%b exp=0", err_tag_mismatch); end
    @(negedge clk);
    #1;
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_resp_once got=%b exp=0000", resp_valid); end
  endtask

  task automatic test_rr_fairness();
    logic [N-1:0] exp;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        for (int i = 0; i < N; i++) set_req(i, CW'(i), WW'(i + 100), WW'(i));
      end
      #1;
      exp = '0;
      exp[k % N] = 1'b1;
      checks++; if (req_ready !== exp) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready, exp); end
    end
    clear_inputs();
  endtask

  task automatic test_hazard();
    do_reset();
    @(negedge clk);
    set_req(0, 5'd7, 16'h11, 16'h1);
    set_req(1, 5'd7, 16'h22, 16'h2);
    set_req(2, 5'd9, 16'h33, 16'h3);
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL hz_c0 got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL hz_c1 got=%b exp=0100", req_ready); end
    checks++; if (eng_req_class_id !== 5'd7) begin errors++; $display("FAIL hz_issue_c1 got=%0d exp=7", eng_req_class_id); end
    @(negedge clk);
    req_valid[2] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL hz_c2_blocked got=%b exp=0000", req_ready); end
    checks++; if (eng_req_class_id !== 5'd9) begin errors++; $display("FAIL hz_issue_c2 got=%0d exp=9", eng_req_class_id); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL hz_c3 got=%b exp=0010", req_ready); end
    checks++; if (eng_req_valid !== 1'b0) begin errors++; $display("FAIL hz_gap_c3 got=%b exp=0", eng_req_valid); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    #1;
    checks++; if (eng_req_valid !== 1'b1 || eng_req_div_quotient !== 16'h22) begin
      errors++; $display("FAIL hz_issue_c4 got=%b/%h exp=1/0022", eng_req_valid, eng_req_div_quotient); end
  endtask

  task automatic test_deq_tracking();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      deq_valid = (c == 4 || c == 9);
      deq_overflow = (c == 9) ? 1'b0 : 1'b1;
      deq_round = (c == 4) ? 18'h100 : (c == 9) ? 18'h2a : RW'($urandom);
      #1;
      if (c <= 4) begin
        checks++; if (eng_last_pifo_valid !== 1'b0) begin errors++; $display("FAIL deq_early c=%0d got=%b exp=0", c, eng_last_pifo_valid); end
      end else if (c <= 9) begin
        checks++; if ({eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round} !== {1'b1, 1'b1, 18'h100}) begin
          errors++; $display("FAIL deq_hold c=%0d got=%b/%b/%h exp=1/1/00100", c, eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round); end
      end else begin
        checks++; if ({eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round} !== {1'b1, 1'b0, 18'h2a}) begin
          errors++; $display("FAIL deq_update got=%b/%b/%h exp=1/0/0002a", eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_mismatch();
    do_reset();
    @(negedge clk);
    eng_resp_valid = 1'b1;
    eng_resp_data  = 32'hdeadbeef;
    #1;
    checks++; if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL mm_before got=%b exp=0", err_tag_mismatch); end
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      eng_resp_valid = 1'b0;
      #1;
      checks++; if (err_tag_mismatch !== 1'b1) begin errors++; $display("FAIL mm_sticky c=%0d got=%b exp=1", c, err_tag_mismatch); end
      checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL mm_dropped c=%0d got=%b exp=0000", c, resp_valid); end
    end
    do_reset();
    #1;
    checks++; if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL mm_cleared got=%b exp=0", err_tag_mismatch); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    @(negedge clk);
    set_req(0, 5'd3, 16'h5, 16'h6);
    deq_valid = 1'b1; deq_overflow = 1'b1; deq_round = 18'h55;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmf_c0 got=%b exp=0001", req_ready); end
    @(negedge clk);
    req_valid[0] = 1'b0;
    deq_valid = 1'b0;
    set_req(1, 5'd3, 16'h7, 16'h8);
    set_req(2, 5'd4, 16'h9, 16'ha);
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmf_c1 got=%b exp=0100", req_ready); end
    @(negedge clk);
    req_valid[2] = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmf_c2_blocked got=%b exp=0000", req_ready); end
    checks++; if (eng_req_valid !== 1'b1 || eng_last_pifo_valid !== 1'b1) begin
      errors++; $display("FAIL rmf_pre got=%b/%b exp=1/1", eng_req_valid, eng_last_pifo_valid); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if ({req_ready, eng_req_valid, eng_req_class_id, eng_last_pifo_valid, eng_last_pifo_round, resp_valid, err_tag_mismatch} !== '0) begin
      errors++; $display("FAIL rmf_async got=%b/%b/%0d/%b/%h/%b/%b exp=all zero", req_ready, eng_req_valid, eng_req_class_id,
                         eng_last_pifo_valid, eng_last_pifo_round, resp_valid, err_tag_mismatch); end
    #1;
    rst = 1'b0;
    set_req(3, 5'd8, 16'hb, 16'hc);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmf_after got=%b exp=0010", req_ready); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (eng_req_valid !== 1'b1 || eng_req_class_id !== 5'd3) begin
      errors++; $display("FAIL rmf_issue got=%b/%0d exp=1/3", eng_req_valid, eng_req_class_id); end
  endtask

  task automatic test_random();
    bit            hold [N];
    logic [CW-1:0] mc [N];
    logic [WW-1:0] mq [N];
    logic [WW-1:0] mr [N];
    int            last_acc [32];
    int            ptr;
    int            g;
    int            idx;
    logic [N-1:0]  xr;
    bit            lpv;
    logic [OW-1:0] lpo;
    logic [RW-1:0] lpr;
    logic [31:0]   rnd;
    for (int i = 0; i < 512; i++) begin
      x_ev[i] = 0; x_dv[i] = 0; x_rv[i] = '0; x_ec[i] = '0; x_eq[i] = '0; x_er[i] = '0; x_dd[i] = '0; x_rd[i] = '0;
    end
    for (int i = 0; i < 32; i++) last_acc[i] = -100;
    for (int i = 0; i < N; i++) begin hold[i] = 0; mc[i] = '0; mq[i] = '0; mr[i] = '0; end
    ptr = 0; lpv = 0; lpo = '0; lpr = '0;
    do_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && c < NCYC - 12 && ($urandom % 3) == 0) begin
          hold[i] = 1;
          rnd = $urandom;
          mc[i] = CW'(rnd[1:0]);
          mq[i] = rnd[31:16];
          mr[i] = rnd[15:0];
        end
        if (hold[i]) set_req(i, mc[i], mq[i], mr[i]);
        else begin
          rnd = $urandom;
          req_valid[i] = 1'b0;
          req_class_id[i*CW +: CW] = rnd[4:0];
        end
      end
      eng_resp_valid = x_dv[c];
      eng_resp_data  = x_dd[c];
      rnd = $urandom;
      deq_valid = (rnd[1:0] == 2'b00);
      deq_overflow = rnd[2];
      deq_round = rnd[31:14];
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
        idx = (ptr + k) % N;
        if (g < 0 && hold[idx] && (c - last_acc[mc[idx]] > 2)) g = idx;
      end
      xr = '0;
      if (g >= 0) xr[g] = 1'b1;
      checks++; if (req_ready !== xr) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, req_ready, xr); end
      checks++; if (eng_req_valid !== x_ev[c]) begin errors++; $display("FAIL rnd_issue_valid c=%0d got=%b exp=%b", c, eng_req_valid, x_ev[c]); end
      if (x_ev[c]) begin
        checks++; if ({eng_req_class_id, eng_req_div_quotient, eng_req_div_remain} !== {x_ec[c], x_eq[c], x_er[c]}) begin
          errors++; $display("FAIL rnd_issue_data c=%0d got=%0d/%h/%h exp=%0d/%h/%h", c, eng_req_class_id,
                             eng_req_div_quotient, eng_req_div_remain, x_ec[c], x_eq[c], x_er[c]); end
      end
      checks++; if (resp_valid !== x_rv[c]) begin errors++; $display("FAIL rnd_resp_valid c=%0d got=%b exp=%b", c, resp_valid, x_rv[c]); end
      if (x_rv[c] != '0) begin
        checks++; if (resp_data !== x_rd[c]) begin errors++; $display("FAIL rnd_resp_data c=%0d got=%h exp=%h", c, resp_data, x_rd[c]); end
      end
      checks++; if (err_tag_mismatch !== 1'b0) begin errors++; $display("FAIL rnd_err c=%0d got=%b exp=0", c, err_tag_mismatch); end
      checks++; if ({eng_last_pifo_valid, eng_last_pifo_overflow, eng_last_pifo_round} !== {lpv, lpo, lpr}) begin
        errors++; $display("FAIL rnd_last_pifo c=%0d got=%b/%b/%h exp=%b/%b/%h", c, eng_last_pifo_valid,
                           eng_last_pifo_overflow, eng_last_pifo_round, lpv, lpo, lpr); end
      if (g >= 0) begin
        hold[g] = 0;
        last_acc[mc[g]] = c;
        ptr = (g + 1) % N;
        x_ev[c+1] = 1; x_ec[c+1] = mc[g]; x_eq[c+1] = mq[g]; x_er[c+1] = mr[g];
        x_dv[c+4] = 1; x_dd[c+4] = $urandom;
        x_rv[c+5] = xr; x_rd[c+5] = x_dd[c+4];
      end
      if (deq_valid) begin lpv = 1; lpo = deq_overflow; lpr = deq_round; end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single();
    test_rr_fairness();
    test_hazard();
    test_deq_tracking();
    test_mismatch();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wfq_req_arbiter.md
Name: wfq_req_arbiter

Overview:
- Shares one WFQ rank-calculation engine (3-stage pipe, per-class round/overflow state) between NUM_REQ ingress requesters.
- Round-robin arbitration with a class-hazard scoreboard. A class is never re-issued while the engine's read-modify-write of that class is still in flight.
- Routes each engine result back to the requester that issued it.
- Tracks the last dequeued PIFO rank and feeds it to the engine's last_pifo inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- REQ_IDX_WIDTH, 2, requester index width, equal to clog2(NUM_REQ)
- CLASS_WIDTH, 5, class id width
- WEIGHT_WIDTH, 16, quotient and remainder width
- PIFO_OVERFLOW_WIDTH, 1, overflow field width
- PIFO_ROUND_WIDTH, 18, round field width
- RESULT_WIDTH, 32, engine result width
- ENGINE_LAT, 3, cycles from engine request to engine response

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant (one-hot or zero)
- req_class_id  in  NUM_REQ*CLASS_WIDTH  packed class ids, requester i at slice i
- req_div_quotient  in  NUM_REQ*WEIGHT_WIDTH  packed quotients
- req_div_remain  in  NUM_REQ*WEIGHT_WIDTH  packed remainders
- eng_req_valid  out  1  engine request valid
- eng_req_class_id  out  CLASS_WIDTH  engine class id
- eng_req_div_quotient  out  WEIGHT_WIDTH  engine quotient
- eng_req_div_remain  out  WEIGHT_WIDTH  engine remainder
- eng_last_pifo_valid  out  1  last-dequeue state valid
- eng_last_pifo_overflow  out  PIFO_OVERFLOW_WIDTH  last dequeued overflow
- eng_last_pifo_round  out  PIFO_ROUND_WIDTH  last dequeued round
- eng_resp_valid  in  1  engine result valid
- eng_resp_data  in  RESULT_WIDTH  engine result
- deq_valid  in  1  PIFO dequeue event
- deq_overflow  in  PIFO_OVERFLOW_WIDTH  dequeued overflow
- deq_round  in  PIFO_ROUND_WIDTH  dequeued round
- resp_valid  out  NUM_REQ  one-hot result strobe
- resp_data  out  RESULT_WIDTH  result
- err_tag_mismatch  out  1  sticky error flag

Behaviour:
- Reset state: all outputs 0, RR pointer 0, scoreboard empty, tag pipe empty. Reset is asynchronous and may assert at any cycle. The top level drives the engine reset from the same source.
- Eligibility: requester i is eligible when req_valid[i]=1 and its class is not in the scoreboard.
- Grant: the first eligible requester searching upward from the RR pointer, with wrap-around. req_ready is combinational and asserted only for the winner; at most one bit is set. A transfer occurs when valid and ready are both high.
- RR pointer: after a grant, pointer = (winner+1) mod NUM_REQ. With no grant, the pointer is held.
- Issue: registered. A transfer accepted in cycle t drives eng_req_valid=1 with the captured class, quotient and remainder in cycle t+1. eng_req_valid is 0 in any cycle not preceded by a transfer.
- Scoreboard: a shift register of depth HZ = ENGINE_LAT-1 (=2), holding the valid bit and class of each transfer.
  - A class accepted in cycle t is blocked in cycles t+1..t+HZ.
  - It is eligible again at t+HZ+1, when the engine's state write is visible to its stage-1 read.
  - Different classes may issue back-to-back, one per cycle.
- Blocked requester: it keeps req_valid high and is skipped. The pointer is unchanged by a skip.
- Tag pipe: the requester index is shifted alongside each issue, ENGINE_LAT stages after eng_req_valid.
- Response path: when eng_resp_valid=1 and the tail tag is valid, then in the next cycle resp_valid[tag]=1 and resp_data=eng_resp_data. Otherwise resp_valid=0.
- Total latency, transfer to resp_valid: ENGINE_LAT+2 = 5 cycles.
- err_tag_mismatch: set when eng_resp_valid differs from the tail-tag valid. On a mismatch with no tag, the response is dropped. The flag stays set until rst.
- Last-PIFO tracker:
  - On deq_valid, capture deq_overflow and deq_round into eng_last_pifo_*; these are visible the next cycle.
  - eng_last_pifo_valid is set on the first deq_valid and stays high until rst.
  - The tracker is independent of issue. A dequeue coinciding with an issue is captured normally; the issued request sees the new value in its stage-1 cycle.
- Arithmetic: none beyond the RR modulo and shifting; no width conversion; data passes through bit-exact.

Test Plan:
- Single request: requester 2 drives class 5, quotient 10, remain 0 at cycle 0. Required: req_ready=4'b0100 at cycle 0, eng_req_valid with class 5 at cycle 1, and resp_valid=4'b0100 at cycle 5 when eng_resp_data is returned at cycle 4.
- RR fairness: all four requesters held valid with distinct classes 0..3. Required: grants 0,1,2,3,0 on consecutive cycles and a one-hot req_ready each cycle.
- Hazard: requesters 0 and 1 both use class 7, requester 2 uses class 9, all valid at cycle 0.
  - Cycle 0: grant 0. Cycle 1: grant 2 (requester 1 blocked).
  - Cycle 2: no grant (requester 1 still blocked), eng_req_valid=0 at cycle 3.
  - Cycle 3: grant 1.
- Dequeue tracking: deq_valid with overflow 1, round 0x100 at cycle 4. Required: eng_last_pifo_valid=1, overflow 1, round 0x100 from cycle 5, held until the next deq_valid.
- Mismatch: inject eng_resp_valid with the tag pipe empty. Required: resp_valid stays 0, err_tag_mismatch=1 from the next cycle and stays high until rst.
- Reset mid-flight: assert rst asynchronously two cycles after a grant. Required: all outputs 0 immediately, RR pointer 0 and scoreboard empty after release, so the same class is grantable in the first cycle after release.
